// File: rtl/frame_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_ctrl_if
//  Description : Handshake and pixel-pair address bus between the frame
//                sequencer (master) and the image_write sink (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_stream_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic              start;
    logic              abort;
    logic              ready;
    logic              VSYNC;
    logic              HSYNC;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       row;
    logic [15:0]       col;
    logic              busy;
    logic              ctrl_done;

    modport master (
        input  start, abort, ready,
        output VSYNC, HSYNC, mem_addr, row, col, busy, ctrl_done
    );

    modport slave (
        output start, abort, ready,
        input  VSYNC, HSYNC, mem_addr, row, col, busy, ctrl_done
    );
endinterface
`default_nettype wire

// File: rtl/frame_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : frame_stream_ctrl
//  Description : Sequences one frame of pixel-pair traffic: VSYNC window,
//                per-line blanking, HSYNC-qualified pair addresses with
//                back-pressure stall, and a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_stream_ctrl #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int VSYNC_CYC  = 100,
    parameter int HBLANK_CYC = 160,
    parameter int ADDR_W     = 19
) (
    input  wire logic           HCLK,
    input  wire logic           HRESET,
    frame_stream_ctrl_if.master bus
);

    // Down-counter shared by the VSYNC and HBLANK phases; sized for the longer one.
    localparam int c_cnt_max = (VSYNC_CYC > HBLANK_CYC) ? VSYNC_CYC : HBLANK_CYC;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_vsync_load  = c_cnt_w'(VSYNC_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hblank_load = c_cnt_w'(HBLANK_CYC - 1);
    localparam logic [15:0]        c_last_col    = 16'(WIDTH - 2);
    localparam logic [15:0]        c_last_row    = 16'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  c_addr_step   = ADDR_W'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_HBLANK = 3'd2,
        S_ACTIVE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_vsync;
    logic                r_hsync;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_row;
    logic [15:0]         r_col;
    logic                r_busy;
    logic                r_done;

    // Transfer happens only while a pair is being presented and the sink takes it.
    logic w_xfer;
    assign w_xfer = r_hsync & bus.ready;

    // Frame sequencer: state, counters and every output are registered here.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.abort) begin
            // Abort beats start in IDLE and cancels any frame without a done pulse.
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_addr  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_addr <= '0;
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_VSYNC;
                        r_cnt   <= c_vsync_load;
                        r_vsync <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                S_VSYNC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HBLANK;
                        r_cnt   <= c_hblank_load;
                        r_vsync <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_HBLANK: begin
                    if (r_cnt == '0) begin
                        r_state <= S_ACTIVE;
                        r_hsync <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                S_ACTIVE: begin
                    // Without a transfer everything holds, so no pair is dropped or skipped.
                    if (w_xfer) begin
                        if (r_col == c_last_col) begin
                            r_hsync <= 1'b0;
                            r_col   <= '0;
                            if (r_row == c_last_row) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                                r_row   <= '0;
                                r_addr  <= '0;
                            end else begin
                                // Lines are stored back to back, so the address just keeps counting.
                                r_state <= S_HBLANK;
                                r_cnt   <= c_hblank_load;
                                r_row   <= r_row + 16'd1;
                                r_addr  <= r_addr + c_addr_step;
                            end
                        end else begin
                            r_col  <= r_col + 16'd2;
                            r_addr <= r_addr + c_addr_step;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_vsync <= 1'b0;
                    r_hsync <= 1'b0;
                    r_addr  <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.VSYNC     = r_vsync;
    assign bus.HSYNC     = r_hsync;
    assign bus.mem_addr  = r_addr;
    assign bus.row       = r_row;
    assign bus.col       = r_col;
    assign bus.busy      = r_busy;
    assign bus.ctrl_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_stream_ctrl
//  Description : Directed self-checking bench for frame_stream_ctrl with a
//                4x2 frame, VSYNC_CYC=3, HBLANK_CYC=2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_stream_ctrl;

    localparam int c_addr_w = 19;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    frame_stream_ctrl_if #(.ADDR_W(c_addr_w)) bus ();

    frame_stream_ctrl #(
        .WIDTH      (4),
        .HEIGHT     (2),
        .VSYNC_CYC  (3),
        .HBLANK_CYC (2),
        .ADDR_W     (c_addr_w)
    ) dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario never returns.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Start sampled at the next rising edge (edge 0); the next negedge lies in cycle 1.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done} !== 4'b0000 ||
            {bus.mem_addr, bus.row, bus.col} !== '0) begin
            n_fail++;
            $display("FAIL reset: flags got %b addr %0d row %0d col %0d, want all 0",
                     {bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done}, bus.mem_addr, bus.row, bus.col);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b want 0", bus.busy);
        end
    endtask

    // Basic frame; with repulse=1 a second start is presented during cycle 7 and must not matter.
    task automatic test_basic_frame(input bit repulse);
        logic [3:0] exp_f;
        int         ea, er, ec;
        pulse_start();
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            bus.start = repulse && (c == 7);
            exp_f = {c <= 12, c >= 1 && c <= 3, c == 6 || c == 7 || c == 10 || c == 11, c == 12};
            n_tests++;
            if ({bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done} !== exp_f) begin
                n_fail++;
                $display("FAIL basic(rep=%0d) c%0d busy/vs/hs/done got %b want %b",
                         repulse, c, {bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done}, exp_f);
            end
            if (exp_f[1] || c == 13) begin
                ea = (c == 6) ? 0 : (c == 7) ? 2 : (c == 10) ? 4 : (c == 11) ? 6 : 0;
                er = (c == 10 || c == 11) ? 1 : 0;
                ec = (c == 7 || c == 11) ? 2 : 0;
                n_tests++;
                if ({bus.mem_addr, bus.row, bus.col} !== {19'(ea), 16'(er), 16'(ec)}) begin
                    n_fail++;
                    $display("FAIL basic_addr(rep=%0d) c%0d got addr %0d row %0d col %0d want %0d %0d %0d",
                             repulse, c, bus.mem_addr, bus.row, bus.col, ea, er, ec);
                end
            end
        end
        bus.start = 1'b0;
    endtask

    // Sink refuses the pairs at edges 6, 7 and 8: addr 0 held cycles 6-9, done slips to 15.
    task automatic test_back_pressure();
        logic [3:0] exp_f;
        int         ea;
        pulse_start();
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus.ready = !(c >= 6 && c <= 8);
            exp_f = {c <= 15, c <= 3, (c >= 6 && c <= 10) || c == 13 || c == 14, c == 15};
            n_tests++;
            if ({bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done} !== exp_f) begin
                n_fail++;
                $display("FAIL backpressure c%0d busy/vs/hs/done got %b want %b",
                         c, {bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done}, exp_f);
            end
            if (exp_f[1]) begin
                ea = (c <= 9) ? 0 : (c == 10) ? 2 : (c == 13) ? 4 : 6;
                n_tests++;
                if (bus.mem_addr !== 19'(ea)) begin
                    n_fail++;
                    $display("FAIL backpressure_addr c%0d got %0d want %0d", c, bus.mem_addr, ea);
                end
            end
        end
        bus.ready = 1'b1;
    endtask

    task automatic test_abort();
        pulse_start();
        for (int c = 1; c <= 10; c++) @(negedge clk);
        n_tests++;
        if (bus.HSYNC !== 1'b1 || bus.mem_addr !== 19'd4) begin
            n_fail++;
            $display("FAIL abort_pre: hs %b addr %0d want hs 1 addr 4", bus.HSYNC, bus.mem_addr);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_tests++;
        if ({bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done} !== 4'b0000 ||
            {bus.mem_addr, bus.row, bus.col} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: flags %b addr %0d row %0d col %0d want all 0",
                     {bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done}, bus.mem_addr, bus.row, bus.col);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.ctrl_done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_nodone: done %b busy %b want 0 0", bus.ctrl_done, bus.busy);
            end
        end
        // Abort together with start in IDLE: stays IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b0 || bus.VSYNC !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_wins: busy %b vs %b want 0 0", bus.busy, bus.VSYNC);
        end
        // A fresh frame afterwards starts from address 0 and completes.
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 6) begin
                n_tests++;
                if (bus.HSYNC !== 1'b1 || bus.mem_addr !== 19'd0) begin
                    n_fail++;
                    $display("FAIL abort_restart: hs %b addr %0d want 1 0", bus.HSYNC, bus.mem_addr);
                end
            end
        end
        n_tests++;
        if (bus.ctrl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart_done: done %b want 1", bus.ctrl_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.VSYNC !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: vs %b want 1", bus.VSYNC);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_now: flags %b want 0000",
                     {bus.busy, bus.VSYNC, bus.HSYNC, bus.ctrl_done});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0 || bus.VSYNC !== 1'b0 || bus.HSYNC !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_idle: busy %b vs %b hs %b want 0 0 0",
                         bus.busy, bus.VSYNC, bus.HSYNC);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_frame(1'b0);
        test_back_pressure();
        test_basic_frame(1'b1);
        test_abort();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
